// File: rtl/ddr_pkg.sv
// ============================================================================
// Module  : ddr_pkg
// Purpose : Shared definitions for the DDR line adapter: controller state
//           encodings, MIG app_cmd constants and a beat-index width helper.
// Ports   : none (package)
// Options : DDR_BYTE_MASK_EN is consumed by ddr_line_adapter, not here.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package ddr_pkg;

  // State encoding is exported on ddr_ctrl_status, so values are fixed.
  typedef enum logic [2:0] {
    CALIB = 3'd0,
    IDLE  = 3'd1,
    RD    = 3'd2,
    WR    = 3'd3,
    DONE  = 3'd4
  } ddr_state_e;

  localparam logic [2:0] CMD_WR = 3'b000;
  localparam logic [2:0] CMD_RD = 3'b001;

  // Width of a beat-slot index; never zero so single-beat lines still elaborate.
  function automatic int beat_idx_w(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ddr_beat_counter.sv
// ============================================================================
// Module  : ddr_beat_counter
// Purpose : Saturating beat counter 0..BEATS used for the command, write-data
//           and read-data streams of the line adapter.
// Ports   : clk      - clock (rising edge)
//           rst      - synchronous active-low reset
//           clear_i  - synchronous clear
//           inc_i    - advance by one (ignored once full)
//           cnt_o    - current count
//           full_o   - count has reached BEATS
//           last_o   - the final increment is taking place this cycle
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ddr_beat_counter #(
  parameter int BEATS = 2,
  parameter int CNT_W = $clog2(BEATS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             full_o,
  output logic             last_o
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (clear_i) begin
      cnt_q <= '0;
    end else if (inc_i && !full_o) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign cnt_o  = cnt_q;
  assign full_o = (cnt_q == CNT_W'(BEATS));
  assign last_o = inc_i && (cnt_q == CNT_W'(BEATS - 1));

endmodule

`default_nettype wire

// File: rtl/ddr_line_adapter.sv
// ============================================================================
// Module  : ddr_line_adapter
// Purpose : Bridges a LINE_W-bit cache line port to the MIG 7-series app_*
//           interface. A line access becomes BEATS = LINE_W/MIG_DATA_W
//           single-beat MIG commands; read beats are reassembled in order.
//           Command and write-data streams advance independently.
// Ports   : clk, rst (sync active-low), init_calib_complete
//           MIG side : mig_rdy, mig_wdf_rdy, mig_data_valid, data_from_mig,
//                      cmd_to_mig, app_en, addr_to_mig, app_wdf_wren,
//                      app_wdf_end, data_to_mig, app_wdf_mask
//           CPU side : ram_en, ram_write, ram_addr, data_to_ram,
//                      [ram_wmask], ram_rdy, data_to_cpu
//           Status   : ddr_ctrl_status (state encoding)
// Options : `define DDR_BYTE_MASK_EN adds ram_wmask (1 = skip byte) which is
//           driven per beat onto app_wdf_mask; otherwise the mask is 0.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ddr_line_adapter
  import ddr_pkg::*;
#(
  parameter int LINE_W     = 256,
  parameter int MIG_DATA_W = 128,
  parameter int ADDR_W     = 30,
  parameter int MIG_ADDR_W = 27,
  parameter int ADDR_STEP  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    init_calib_complete,
  input  logic                    mig_rdy,
  input  logic                    mig_wdf_rdy,
  input  logic                    mig_data_valid,
  input  logic [MIG_DATA_W-1:0]   data_from_mig,
  input  logic                    ram_en,
  input  logic                    ram_write,
  input  logic [ADDR_W-1:0]       ram_addr,
  input  logic [LINE_W-1:0]       data_to_ram,
`ifdef DDR_BYTE_MASK_EN
  input  logic [LINE_W/8-1:0]     ram_wmask,
`endif
  output logic [2:0]              cmd_to_mig,
  output logic                    app_en,
  output logic [MIG_ADDR_W-1:0]   addr_to_mig,
  output logic                    app_wdf_wren,
  output logic                    app_wdf_end,
  output logic [MIG_DATA_W-1:0]   data_to_mig,
  output logic [MIG_DATA_W/8-1:0] app_wdf_mask,
  output logic                    ram_rdy,
  output logic [LINE_W-1:0]       data_to_cpu,
  output logic [3:0]              ddr_ctrl_status
);

  localparam int BEATS  = LINE_W / MIG_DATA_W;
  localparam int CNT_W  = $clog2(BEATS + 1);
  localparam int IDX_W  = beat_idx_w(BEATS);
  localparam int OFF_W  = $clog2(LINE_W / 32);
  localparam int MASK_W = MIG_DATA_W / 8;

  ddr_state_e             state_q;
  logic                   write_q;
  logic                   ram_rdy_q;
  logic [MIG_ADDR_W-1:0]  base_q;
  logic [LINE_W-1:0]      line_q;
  logic [LINE_W-1:0]      cpu_q;

  logic [CNT_W-1:0] cmd_cnt, wdf_cnt, rd_cnt;
  logic             cmd_full, wdf_full, rd_full;
  logic             cmd_last, wdf_last, rd_last;
  logic [IDX_W-1:0] wdf_idx, rd_idx;

  logic             busy, cmd_inc, wdf_inc, rd_inc, cnt_clear;
  logic [ADDR_W-1:0]     line_addr;
  logic [MIG_ADDR_W-1:0] base_d;

  // Word address -> line-aligned, then doubled into x16 column units.
  assign line_addr = ram_addr & ~ADDR_W'((1 << OFF_W) - 1);
  assign base_d    = MIG_ADDR_W'({line_addr, 1'b0});

  assign busy      = (state_q == RD) || (state_q == WR);
  assign cmd_inc   = app_en && mig_rdy;
  assign wdf_inc   = app_wdf_wren && mig_wdf_rdy;
  // Beats outside RD (e.g. stragglers after a reset) are dropped here.
  assign rd_inc    = (state_q == RD) && mig_data_valid && !rd_full;
  assign cnt_clear = (state_q == IDLE);

  ddr_beat_counter #(.BEATS(BEATS), .CNT_W(CNT_W)) u_cmd_cnt (
    .clk(clk), .rst(rst), .clear_i(cnt_clear), .inc_i(cmd_inc),
    .cnt_o(cmd_cnt), .full_o(cmd_full), .last_o(cmd_last));

  ddr_beat_counter #(.BEATS(BEATS), .CNT_W(CNT_W)) u_wdf_cnt (
    .clk(clk), .rst(rst), .clear_i(cnt_clear), .inc_i(wdf_inc),
    .cnt_o(wdf_cnt), .full_o(wdf_full), .last_o(wdf_last));

  ddr_beat_counter #(.BEATS(BEATS), .CNT_W(CNT_W)) u_rd_cnt (
    .clk(clk), .rst(rst), .clear_i(cnt_clear), .inc_i(rd_inc),
    .cnt_o(rd_cnt), .full_o(rd_full), .last_o(rd_last));

  // Slot indices; when a count sits at BEATS the truncated index wraps to a
  // valid slot, which is harmless because the matching valid is low.
  generate
    if (BEATS > 1) begin : g_idx_multi
      assign wdf_idx = wdf_cnt[IDX_W-1:0];
      assign rd_idx  = rd_cnt[IDX_W-1:0];
    end else begin : g_idx_single
      assign wdf_idx = '0;
      assign rd_idx  = '0;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= CALIB;
      write_q   <= 1'b0;
      ram_rdy_q <= 1'b0;
      base_q    <= '0;
      line_q    <= '0;
    end else begin
      case (state_q)
        CALIB: if (init_calib_complete) state_q <= IDLE;
        IDLE: begin
          if (ram_en) begin
            write_q <= ram_write;
            base_q  <= base_d;
            line_q  <= data_to_ram;
            state_q <= ram_write ? WR : RD;
          end
        end
        RD: begin
          if (rd_last) begin
            state_q   <= DONE;
            ram_rdy_q <= 1'b1;
          end
        end
        WR: begin
          // Either stream may finish first, or both on the same edge.
          if ((cmd_full || cmd_last) && (wdf_full || wdf_last)) begin
            state_q   <= DONE;
            ram_rdy_q <= 1'b1;
          end
        end
        DONE: begin
          if (!ram_en) begin
            state_q   <= IDLE;
            ram_rdy_q <= 1'b0;
          end
        end
        default: state_q <= CALIB;
      endcase
    end
  end

  // Read line assembly; untouched slots keep the previous line.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cpu_q <= '0;
    end else if (rd_inc) begin
      cpu_q[rd_idx*MIG_DATA_W +: MIG_DATA_W] <= data_from_mig;
    end
  end

`ifdef DDR_BYTE_MASK_EN
  logic [LINE_W/8-1:0] mask_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      mask_q <= '0;
    end else if (state_q == IDLE && ram_en) begin
      mask_q <= ram_wmask;
    end
  end

  assign app_wdf_mask = mask_q[wdf_idx*MASK_W +: MASK_W];
`else
  assign app_wdf_mask = '0;
`endif

  assign app_en          = busy && !cmd_full;
  assign app_wdf_wren    = (state_q == WR) && !wdf_full;
  assign app_wdf_end     = app_wdf_wren;
  assign cmd_to_mig      = write_q ? CMD_WR : CMD_RD;
  assign addr_to_mig     = base_q + MIG_ADDR_W'(cmd_cnt * ADDR_STEP);
  assign data_to_mig     = line_q[wdf_idx*MIG_DATA_W +: MIG_DATA_W];
  assign ram_rdy         = ram_rdy_q;
  assign data_to_cpu     = cpu_q;
  assign ddr_ctrl_status = {1'b0, state_q};

endmodule

`default_nettype wire

// File: tb/tb_ddr_line_adapter.sv
// ============================================================================
// Module  : tb_ddr_line_adapter
// Purpose : Directed bench for ddr_line_adapter: a 256-bit instance covers
//           calibration, read, write with command stall and reset abort; a
//           512-bit instance covers a stalled four-beat read.
// Options : DDR_BYTE_MASK_EN enables the per-beat mask checks.
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_ddr_line_adapter;

  localparam int MW = 128;
  localparam logic [MW-1:0] A  = 128'hAAAA_0001_1111_2222_3333_4444_5555_6666;
  localparam logic [MW-1:0] B  = 128'hBBBB_0002_7777_8888_9999_AAAA_BBBB_CCCC;
  localparam logic [MW-1:0] W0 = 128'h0000_1000_DEAD_BEEF_0123_4567_89AB_CDEF;
  localparam logic [MW-1:0] W1 = 128'h1111_2000_CAFE_F00D_FEDC_BA98_7654_3210;
  localparam logic [MW-1:0] E0 = 128'hE0E0_E0E0_E0E0_E0E0_E0E0_E0E0_E0E0_E0E0;
  localparam logic [MW-1:0] E1 = 128'hE1E1_E1E1_E1E1_E1E1_E1E1_E1E1_E1E1_E1E1;
  localparam logic [MW-1:0] F0 = 128'hF000_0000_0000_0000_0000_0000_0000_0F00;
  localparam logic [MW-1:0] F1 = 128'hF111_0000_0000_0000_0000_0000_0000_0F11;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, calib, mig_rdy, wdf_rdy, dvalid;
  logic [MW-1:0] dfm;

  logic          en0, wr0, en1, wr1;
  logic [29:0]   addr0, addr1_in;
  logic [255:0]  line0;
  logic [511:0]  line1;

  logic [2:0]    cmd0, cmd1;
  logic          app_en0, app_en1, wren0, wren1, wend0, wend1, rdy0, rdy1;
  logic [26:0]   addr0_out, addr1;
  logic [MW-1:0] wdata0, wdata1;
  logic [15:0]   mask0, mask1;
  logic [255:0]  cpu0;
  logic [511:0]  cpu1;
  logic [3:0]    st0, st1;

`ifdef DDR_BYTE_MASK_EN
  logic [31:0] wmask0;
  logic [63:0] wmask1;
  localparam logic [15:0] M0_EXP = 16'hFFFF;
`else
  localparam logic [15:0] M0_EXP = 16'h0000;
`endif

  ddr_line_adapter u_dut0 (
    .clk(clk), .rst(rst), .init_calib_complete(calib),
    .mig_rdy(mig_rdy), .mig_wdf_rdy(wdf_rdy), .mig_data_valid(dvalid),
    .data_from_mig(dfm), .ram_en(en0), .ram_write(wr0), .ram_addr(addr0),
    .data_to_ram(line0),
`ifdef DDR_BYTE_MASK_EN
    .ram_wmask(wmask0),
`endif
    .cmd_to_mig(cmd0), .app_en(app_en0), .addr_to_mig(addr0_out),
    .app_wdf_wren(wren0), .app_wdf_end(wend0), .data_to_mig(wdata0),
    .app_wdf_mask(mask0), .ram_rdy(rdy0), .data_to_cpu(cpu0),
    .ddr_ctrl_status(st0));

  ddr_line_adapter #(.LINE_W(512)) u_dut1 (
    .clk(clk), .rst(rst), .init_calib_complete(calib),
    .mig_rdy(mig_rdy), .mig_wdf_rdy(wdf_rdy), .mig_data_valid(dvalid),
    .data_from_mig(dfm), .ram_en(en1), .ram_write(wr1), .ram_addr(addr1_in),
    .data_to_ram(line1),
`ifdef DDR_BYTE_MASK_EN
    .ram_wmask(wmask1),
`endif
    .cmd_to_mig(cmd1), .app_en(app_en1), .addr_to_mig(addr1),
    .app_wdf_wren(wren1), .app_wdf_end(wend1), .data_to_mig(wdata1),
    .app_wdf_mask(mask1), .ram_rdy(rdy1), .data_to_cpu(cpu1),
    .ddr_ctrl_status(st1));

  int n_tests = 0;
  int n_fail  = 0;
  int wbeats0 = 0;

  always @(posedge clk) if (wren0 && wdf_rdy) wbeats0++;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int bad, found, acc;
    logic [511:0] exp1;

    rst = 1'b0; calib = 1'b0; mig_rdy = 1'b0; wdf_rdy = 1'b0; dvalid = 1'b0; dfm = '0;
    en0 = 1'b0; wr0 = 1'b0; addr0 = '0; line0 = '0;
    en1 = 1'b0; wr1 = 1'b0; addr1_in = '0; line1 = '0;
`ifdef DDR_BYTE_MASK_EN
    wmask0 = '0; wmask1 = '0;
`endif
    repeat (3) tick();
    chk("rst_app_en", app_en0, 0);
    chk("rst_wren", wren0, 0);
    chk("rst_ram_rdy", rdy0, 0);
    chk("rst_data_to_cpu", cpu0, 0);
    chk("rst_cmd", cmd0, 3'b001);
    chk("rst_status", st0, 0);
    rst = 1'b1;

    // Calibration gate, then first read command within two cycles.
    en0 = 1'b1; wr0 = 1'b0; addr0 = 30'h40; bad = 0;
    repeat (100) begin
      tick();
      if (app_en0 !== 1'b0 || st0 !== 4'd0) bad++;
    end
    chk("calib_hold", bad, 0);
    calib = 1'b1; found = 0;
    for (int k = 0; k < 2 && found == 0; k++) begin
      tick();
      if (app_en0 === 1'b1) found = 1;
    end
    chk("calib_first_cmd", found, 1);

    // 256-bit read at word 0x40.
    chk("rd_cmd0_addr", addr0_out, 27'h80);
    chk("rd_cmd0_cmd", cmd0, 3'b001);
    mig_rdy = 1'b1;
    tick();
    chk("rd_cmd1_addr", addr0_out, 27'h88);
    chk("rd_cmd1_en", app_en0, 1);
    tick();
    chk("rd_cmds_done", app_en0, 0);
    mig_rdy = 1'b0;
    dvalid = 1'b1; dfm = A; tick();
    dfm = B; tick();
    dvalid = 1'b0;
    chk("rd_line", cpu0, {B, A});
    chk("rd_ram_rdy", rdy0, 1);
    chk("rd_status_done", st0, 4);
    repeat (3) tick();
    chk("rd_ram_rdy_hold", rdy0, 1);
    en0 = 1'b0; tick();
    chk("rd_ram_rdy_drop", rdy0, 0);
    chk("rd_back_idle", st0, 1);

    // Write with the command port stalled: data beats go first.
    line0 = {W1, W0}; wr0 = 1'b1; addr0 = 30'h100; en0 = 1'b1;
    wdf_rdy = 1'b1; mig_rdy = 1'b0;
`ifdef DDR_BYTE_MASK_EN
    wmask0 = 32'h0000_FFFF;
`endif
    tick();
    chk("wr_beat0_data", wdata0, W0);
    chk("wr_beat0_wren", wren0, 1);
    chk("wr_beat0_end", wend0, 1);
    chk("wr_beat0_mask", mask0, M0_EXP);
    tick();
    chk("wr_beat1_data", wdata0, W1);
    chk("wr_beat1_mask", mask0, 16'h0000);
    tick();
    chk("wr_data_done", wren0, 0);
    repeat (7) tick();
    chk("wr_stall_addr", addr0_out, 27'h200);
    chk("wr_stall_cmd", cmd0, 3'b000);
    chk("wr_stall_state", st0, 3);
    chk("wr_stall_en", app_en0, 1);
    mig_rdy = 1'b1; tick();
    chk("wr_cmd1_addr", addr0_out, 27'h208);
    tick();
    mig_rdy = 1'b0;
    chk("wr_done_state", st0, 4);
    chk("wr_ram_rdy", rdy0, 1);
    chk("wr_no_extra_cmd", app_en0, 0);
    chk("wr_beat_count", wbeats0, 2);
    en0 = 1'b0; wr0 = 1'b0; tick();
    chk("wr_back_idle", st0, 1);

    // 512-bit read with mig_rdy toggling; low address bits ignored.
    addr1_in = 30'h2B; wr1 = 1'b0; en1 = 1'b1; mig_rdy = 1'b0;
    tick();
    acc = 0;
    for (int c = 0; c < 20; c++) begin
      if (app_en1 !== 1'b1) break;
      chk("rd512_addr", addr1, 27'h40 + 8 * acc);
      chk("rd512_cmd", cmd1, 3'b001);
      mig_rdy = ~mig_rdy;
      if (mig_rdy) acc++;
      tick();
    end
    mig_rdy = 1'b0;
    chk("rd512_cmd_count", acc, 4);
    exp1 = '0;
    for (int i = 0; i < 4; i++) begin
      dvalid = 1'b1;
      dfm = {32'h5100_0000 + 32'(i), 64'h0, 32'h0000_00A0 + 32'(i)};
      exp1[i*MW +: MW] = dfm;
      tick();
    end
    dvalid = 1'b0;
    chk("rd512_line", cpu1, exp1);
    chk("rd512_ram_rdy", rdy1, 1);
    chk("line0_held", cpu0, {B, A});
    en1 = 1'b0; tick();

    // Reset in the middle of a read, straggler beat, then a clean read.
    addr0 = 30'h0; wr0 = 1'b0; en0 = 1'b1; mig_rdy = 1'b1;
    tick(); tick(); tick();
    mig_rdy = 1'b0;
    dvalid = 1'b1; dfm = E0; tick();
    dvalid = 1'b0; en0 = 1'b0; rst = 1'b0; tick();
    chk("abort_app_en", app_en0, 0);
    chk("abort_ram_rdy", rdy0, 0);
    chk("abort_data", cpu0, 0);
    chk("abort_status", st0, 0);
    chk("abort_cmd", cmd0, 3'b001);
    rst = 1'b1; dvalid = 1'b1; dfm = E1; tick();
    dvalid = 1'b0;
    chk("late_beat_dropped", cpu0, 0);
    addr0 = 30'h8; en0 = 1'b1; tick();
    chk("fresh_addr", addr0_out, 27'h10);
    mig_rdy = 1'b1; tick(); tick();
    mig_rdy = 1'b0;
    chk("fresh_cmds_done", app_en0, 0);
    dvalid = 1'b1; dfm = F0; tick();
    dfm = F1; tick();
    dvalid = 1'b0;
    chk("fresh_line", cpu0, {F1, F0});
    chk("fresh_ram_rdy", rdy0, 1);
    en0 = 1'b0; tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
